// File: rtl/cache_def.sv
// Shared definitions for the direct-mapped cache and the arbiter in front of it.
// Contents:
//   cpu_req_type    - request bundle presented to the cache FSM
//   cpu_result_type - result bundle returned by the cache FSM
//   arb_state_e     - arbiter FSM states
//   NUM_REQ_DEFAULT, TIMEOUT_DEFAULT - default arbiter sizing
package cache_def;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   i_req   [N-1:0]  request vector
//   i_ptr   [IW-1:0] index with highest priority this cycle
//   o_grant [N-1:0]  one-hot grant (all zero when nothing requests)
//   o_idx   [IW-1:0] index of the granted requester
//   o_any            at least one requester is granted
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from i_ptr upward, wrapping at N; the first requester found wins.
  always_comb begin
    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = {1'b0, i_ptr} + (IW + 1)'(off);
      if (w_sum >= (IW + 1)'(N)) begin
        w_sum = w_sum - (IW + 1)'(N);
      end
      w_pos = w_sum[IW-1:0];
      if (!o_any && i_req[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/dm_cache_arb_downstream.sv
// Arbitrates NUM_REQ requesters onto the single request port of the
// downstream direct-mapped cache FSM, one transaction at a time.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/rw/addr/data per-requester request
//   req_ready             one-hot accept pulse (IDLE only)
//   rsp_valid             one-hot completion pulse (RESP only)
//   rsp_data, rsp_err     completion payload; rsp_err=1 means timed out
//   cache_req, cache_res  downstream cache interface
//   busy                  arbiter not IDLE
//   timeout_err           sticky, set by any timeout, cleared only by reset
module dm_cache_arb_downstream
  import cache_def::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_rw,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  output cpu_req_type              cache_req,
  input  cpu_result_type           cache_res,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [IW-1:0]     r_ptr;
  logic [CW-1:0]     r_wait;
  logic              r_hold_rw;
  logic [31:0]       r_hold_addr;
  logic [31:0]       r_hold_data;
  logic [IW-1:0]     r_hold_idx;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_err;
  logic              r_timeout_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_any;
  logic               w_zero_wr;
  logic               w_timeout;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  // A write of zero has no effect on the accumulating cache, so it is
  // acknowledged without occupying the downstream port.
  assign w_zero_wr = req_rw[w_grant_idx] && (req_data[w_grant_idx] == 32'd0);

  // The counter starts at 0 in the first ISSUE cycle, so the last allowed
  // cycle is the one where it reads TIMEOUT_CYCLES-1. A ready in that same
  // cycle still wins over the timeout.
  assign w_timeout = (r_state == ST_ISSUE) && !cache_res.ready &&
                     (r_wait == CW'(TIMEOUT_CYCLES - 1));

  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_wait        <= '0;
      r_hold_rw     <= 1'b0;
      r_hold_addr   <= '0;
      r_hold_data   <= '0;
      r_hold_idx    <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_hold_rw   <= req_rw[w_grant_idx];
            r_hold_addr <= req_addr[w_grant_idx];
            r_hold_data <= req_data[w_grant_idx];
            r_hold_idx  <= w_grant_idx;
            r_ptr       <= (w_grant_idx == IW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            r_wait      <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (cache_res.ready) begin
            r_rsp_data <= cache_res.data;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b1;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and all outputs; cache_res is only looked at in ISSUE.
  always_comb begin
    w_next_state = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    rsp_data     = '0;
    rsp_err      = 1'b0;
    cache_req    = '0;
    busy         = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          req_ready    = w_grant;
          w_next_state = w_zero_wr ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cache_req.valid = 1'b1;
        cache_req.rw    = r_hold_rw;
        cache_req.addr  = r_hold_addr;
        cache_req.data  = r_hold_data;
        if (cache_res.ready || w_timeout) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid[r_hold_idx] = 1'b1;
        rsp_data              = r_rsp_data;
        rsp_err               = r_rsp_err;
        w_next_state          = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dm_cache_arb_downstream.sv
// Directed testbench for dm_cache_arb_downstream (4 requesters, timeout 8).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_dm_cache_arb_downstream;
  import cache_def::*;

  localparam int NumReq        = 4;
  localparam int TimeoutCycles = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NumReq-1:0]       reqValid;
  logic [NumReq-1:0]       reqRw;
  logic [NumReq-1:0][31:0] reqAddr;
  logic [NumReq-1:0][31:0] reqData;
  logic [NumReq-1:0]       reqReady;
  logic [NumReq-1:0]       rspValid;
  logic [31:0]             rspData;
  logic                    rspErr;
  cpu_req_type             cacheReq;
  cpu_result_type          cacheRes;
  logic                    busy;
  logic                    timeoutErr;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  dm_cache_arb_downstream #(
    .NUM_REQ        (NumReq),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (reqValid),
    .req_rw      (reqRw),
    .req_addr    (reqAddr),
    .req_data    (reqData),
    .req_ready   (reqReady),
    .rsp_valid   (rspValid),
    .rsp_data    (rspData),
    .rsp_err     (rspErr),
    .cache_req   (cacheReq),
    .cache_res   (cacheRes),
    .busy        (busy),
    .timeout_err (timeoutErr)
  );

  // Counts a comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Moves to the next falling edge, applies request inputs and lets them settle.
  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] rw,
                               input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    reqValid       = valid;
    reqRw          = rw;
    cacheRes.ready = rdy;
    cacheRes.data  = rdata;
    #1;
  endtask

  // Checks that every output is at its reset value.
  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_req_ready"}, 32'(reqReady), 32'h0);
    checkOutput({pfx, "_rsp_valid"}, 32'(rspValid), 32'h0);
    checkOutput({pfx, "_rsp_data"}, rspData, 32'h0);
    checkOutput({pfx, "_rsp_err"}, 32'(rspErr), 32'h0);
    checkOutput({pfx, "_creq_valid"}, 32'(cacheReq.valid), 32'h0);
    checkOutput({pfx, "_creq_addr"}, cacheReq.addr, 32'h0);
    checkOutput({pfx, "_busy"}, 32'(busy), 32'h0);
    checkOutput({pfx, "_timeout_err"}, 32'(timeoutErr), 32'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] grantOrder [5];
    grantOrder = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    reqValid = '0;
    reqRw    = '0;
    reqAddr  = '0;
    reqData  = '0;
    cacheRes = '0;

    // Reset values
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from requester 0, hit on first ISSUE cycle with data 0x55
    reqAddr[0] = 32'h0000_0010;
    applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h0);
    checkOutput("rd_accept_ready", 32'(reqReady), 32'h1);
    checkOutput("rd_accept_busy", 32'(busy), 32'h0);
    checkOutput("rd_accept_creq_valid", 32'(cacheReq.valid), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h55);
    checkOutput("rd_issue_valid", 32'(cacheReq.valid), 32'h1);
    checkOutput("rd_issue_addr", cacheReq.addr, 32'h10);
    checkOutput("rd_issue_rw", 32'(cacheReq.rw), 32'h0);
    checkOutput("rd_issue_busy", 32'(busy), 32'h1);
    checkOutput("rd_issue_rsp_valid", 32'(rspValid), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("rd_resp_valid", 32'(rspValid), 32'h1);
    checkOutput("rd_resp_data", rspData, 32'h55);
    checkOutput("rd_resp_err", 32'(rspErr), 32'h0);
    checkOutput("rd_resp_creq_valid", 32'(cacheReq.valid), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("rd_idle_busy", 32'(busy), 32'h0);
    checkOutput("rd_idle_rsp_valid", 32'(rspValid), 32'h0);

    // Reset so the pointer starts at 0, then all four write 0x1 continuously
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      reqAddr[i] = 32'h100 * (i + 1);
      reqData[i] = 32'h1;
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b0, 32'h0);
      checkOutput($sformatf("rr_grant%0d", k), 32'(reqReady), 32'h1 << grantOrder[k]);
      checkOutput($sformatf("rr_idle_creq%0d", k), 32'(cacheReq.valid), 32'h0);
      applyStimulus(4'b1111, 4'b1111, 1'b1, 32'h0);
      checkOutput($sformatf("rr_issue_valid%0d", k), 32'(cacheReq.valid), 32'h1);
      checkOutput($sformatf("rr_issue_addr%0d", k), cacheReq.addr,
                  32'h100 * (32'(grantOrder[k]) + 1));
      checkOutput($sformatf("rr_issue_data%0d", k), cacheReq.data, 32'h1);
      checkOutput($sformatf("rr_issue_busy_ready%0d", k), 32'(reqReady), 32'h0);
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 4'b1111, 1'b0, 32'h0);
      checkOutput($sformatf("rr_gap%0d", k), 32'(cacheReq.valid), 32'h0);
      checkOutput($sformatf("rr_rsp%0d", k), 32'(rspValid), 32'h1 << grantOrder[k]);
    end

    // Requester 2 writes zero: accepted, never issued, answered right after
    reqData[2] = 32'h0;
    applyStimulus(4'b0100, 4'b0100, 1'b0, 32'h0);
    checkOutput("zw_accept_ready", 32'(reqReady), 32'h4);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'hDEAD);
    checkOutput("zw_no_creq", 32'(cacheReq.valid), 32'h0);
    checkOutput("zw_rsp_valid", 32'(rspValid), 32'h4);
    checkOutput("zw_rsp_data", rspData, 32'h0);
    checkOutput("zw_rsp_err", 32'(rspErr), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("zw_idle_busy", 32'(busy), 32'h0);
    checkOutput("zw_idle_creq", 32'(cacheReq.valid), 32'h0);
    checkOutput("zw_no_timeout", 32'(timeoutErr), 32'h0);

    // Requester 1 reads, cache never answers: 8 ISSUE cycles then error
    reqAddr[1] = 32'h0000_1234;
    applyStimulus(4'b0010, 4'b0000, 1'b0, 32'h0);
    checkOutput("to_accept_ready", 32'(reqReady), 32'h2);
    for (int c = 0; c < TimeoutCycles; c++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0, 32'h0);
      checkOutput($sformatf("to_issue%0d", c), 32'(cacheReq.valid), 32'h1);
      checkOutput($sformatf("to_wait_ready%0d", c), 32'(reqReady), 32'h0);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("to_resp_valid", 32'(rspValid), 32'h2);
    checkOutput("to_resp_err", 32'(rspErr), 32'h1);
    checkOutput("to_resp_data", rspData, 32'h0);
    checkOutput("to_flag", 32'(timeoutErr), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'h77);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("to_ready_ignored", 32'(rspValid), 32'h0);
    checkOutput("to_flag_sticky", 32'(timeoutErr), 32'h1);
    checkOutput("to_idle_busy", 32'(busy), 32'h0);

    // Reset in the middle of an ISSUE, then requesters 1 and 0 together
    reqAddr[1] = 32'h0000_2000;
    applyStimulus(4'b0010, 4'b0000, 1'b0, 32'h0);
    checkOutput("mr_accept_ready", 32'(reqReady), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("mr_issue_valid", 32'(cacheReq.valid), 32'h1);
    checkOutput("mr_issue_addr", cacheReq.addr, 32'h2000);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n    = 1'b1;
    reqValid = 4'b0011;
    reqRw    = 4'b0000;
    #1;
    checkOutput("mr_first_grant", 32'(reqReady), 32'h1);
    checkOutput("mr_no_stale_rsp", 32'(rspValid), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 32'hABCD);
    checkOutput("mr_issue_addr0", cacheReq.addr, 32'h100);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 32'h0);
    checkOutput("mr_rsp_valid", 32'(rspValid), 32'h1);
    checkOutput("mr_rsp_data", rspData, 32'hABCD);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
